pc_fetch_stage: RTL and testbench

//  IF stage of the pipeline: owns the PC and drives the instruction-memory request.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 23 ++
 rtl/pc_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared fetch-stage definitions: reset defaults, fetch FSM encoding, word-size helpers.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = '0;
  localparam logic [31:0] NOP_INSTR_DEFAULT = '0;
  localparam int unsigned WORD_BYTES        = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC datapath: branch target adder, branch-over-jump priority mux, PC+4 incrementer.
module pc_next_sel
  import pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_base,
  input  logic [31:0] br_offset_sl2,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  always_comb begin
    redirect = br_taken | jmp;
    // The branch is the older instruction, so it beats a same-cycle jump.
    target   = br_taken ? (br_base + br_offset_sl2) : jmp_target;
    pc_plus4 = pc + 32'(WORD_BYTES);
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: owns the PC, issues instruction fetches and fills the IF/ID latch.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky misalign_fault.
module pc_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_base,
  input  logic [31:0] br_offset_sl2,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        misalign_fault
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         pending_q, pending_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         hold_q, hold_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         req;
  logic         outstanding;
  logic         fire;
  logic         misalign;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .br_taken      (br_taken),
    .br_base       (br_base),
    .br_offset_sl2 (br_offset_sl2),
    .jmp           (jmp),
    .jmp_target    (jmp_target),
    .redirect      (redirect),
    .target        (target),
    .pc_plus4      (pc_plus4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect && outstanding) state_d = DRAIN;
      DRAIN:   if (!redirect && imem_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Stall only gates a new request; an issued one stays up until answered.
  always_comb begin
    req       = 1'b0;
    imem_addr = word_align(pc_q);
    unique case (state_q)
      IDLE:    req = 1'b0;
      FETCH:   req = pending_q | ~id_stall;
      DRAIN: begin
        req       = 1'b1;
        imem_addr = word_align(drain_addr_q);
      end
      default: req = 1'b0;
    endcase
    imem_req    = req;
    outstanding = req & ~imem_ready;
    fire        = (state_q == FETCH) & req & imem_ready;
    misalign    = TRAP_EN && (target[1:0] != 2'b00);
  end

  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    fault_d      = fault_q;
    hold_d       = hold_q;
    pending_d    = (state_q == FETCH) & outstanding & ~redirect;

    if (redirect) begin
      pc_d    = word_align(target);
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      hold_d  = misalign;
      fault_d = fault_q | misalign;
      if ((state_q == FETCH) && outstanding) drain_addr_d = pc_q;
    end else if (fire) begin
      pc_d = pc_plus4;
      if (!hold_q) begin
        valid_d = 1'b1;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
      end
    end else if ((state_q == FETCH) && outstanding) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      pending_q    <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= '0;
      fault_q      <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      pending_q    <= pending_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      fault_q      <= fault_d;
      hold_q       <= hold_d;
    end
  end

  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc4      = pc4_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a transaction-level fetch model checked every cycle.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_base = '0;
  logic [31:0] br_offset_sl2 = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        misalign_fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_stall       (id_stall),
    .br_taken       (br_taken),
    .br_base        (br_base),
    .br_offset_sl2  (br_offset_sl2),
    .jmp            (jmp),
    .jmp_target     (jmp_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory content: a per-address signature so dropped data is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Model: one outstanding request, optionally marked for discard after a redirect.
  logic        m_started, m_busy, m_discard, m_valid, m_fault, m_hold;
  logic [31:0] m_pc, m_busy_addr, m_instr, m_pc4;

  task automatic m_reset();
    m_started = 1'b0; m_busy = 1'b0; m_discard = 1'b0;
    m_valid = 1'b0; m_fault = 1'b0; m_hold = 1'b0;
    m_pc = '0; m_busy_addr = '0; m_instr = NOP; m_pc4 = '0;
  endtask

  function automatic logic m_req_now();
    return m_started && (m_busy || !id_stall);
  endfunction

  function automatic logic [31:0] m_addr_now();
    return m_busy ? m_busy_addr : m_pc;
  endfunction

  task automatic m_update();
    logic        req;
    logic [31:0] addr, tgt;
    logic        bad;
    req  = m_req_now();
    addr = m_addr_now();
    tgt  = br_taken ? (br_base + br_offset_sl2) : jmp_target;
`ifdef PC_MISALIGN_TRAP_EN
    bad = (tgt % 4) != 0;
`else
    bad = 1'b0;
`endif
    if (br_taken || jmp) begin
      m_pc    = tgt - (tgt % 4);
      m_valid = 1'b0;
      m_instr = NOP;
      m_hold  = bad;
      if (bad) m_fault = 1'b1;
      if (m_discard || (req && !imem_ready)) begin
        m_busy      = 1'b1;
        m_busy_addr = addr;
        m_discard   = 1'b1;
      end else begin
        m_busy    = 1'b0;
        m_discard = 1'b0;
      end
    end else if (req && imem_ready) begin
      if (!m_discard) begin
        m_pc = addr + 32'd4;
        if (!m_hold) begin
          m_valid = 1'b1;
          m_instr = mem_word(addr);
          m_pc4   = addr + 32'd4;
        end
      end
      m_busy    = 1'b0;
      m_discard = 1'b0;
    end else if (req) begin
      m_busy      = 1'b1;
      m_busy_addr = addr;
      if (!m_discard) m_valid = 1'b0;
    end
    m_started = 1'b1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_update();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model req", 32'(imem_req), 32'(m_req_now()));
      if (m_req_now()) chk("model addr", imem_addr, m_addr_now());
      chk("model valid", 32'(if_id_valid), 32'(m_valid));
      chk("model instr", if_id_instr, m_instr);
      chk("model pc4", if_id_pc4, m_pc4);
      chk("model fault", 32'(misalign_fault), 32'(m_fault));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_clear();
    br_taken = 1'b0;
    jmp      = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset valid", 32'(if_id_valid), 32'd0);
    chk("reset instr", if_id_instr, NOP);
    chk("reset pc4", if_id_pc4, 32'd0);
    chk("reset fault", 32'(misalign_fault), 32'd0);
    rst_n = 1'b1;

    step();
    chk("first addr", imem_addr, 32'h0);
    chk("first req", 32'(imem_req), 32'd1);
    step();
    chk("addr 4", imem_addr, 32'h4);
    chk("pc4 4", if_id_pc4, 32'h4);
    chk("instr @0", if_id_instr, 32'hC0DE_0001);
    step();
    chk("addr 8", imem_addr, 32'h8);
    chk("pc4 8", if_id_pc4, 32'h8);

    imem_ready = 1'b0;
    step();
    chk("wait1 addr", imem_addr, 32'h8);
    chk("wait1 valid", 32'(if_id_valid), 32'd0);
    step();
    chk("wait2 req", 32'(imem_req), 32'd1);
    chk("wait2 valid", 32'(if_id_valid), 32'd0);
    imem_ready = 1'b1;
    step();
    chk("pc4 12", if_id_pc4, 32'hC);
    chk("instr @8", if_id_instr, 32'hC0DE_0009);

    br_taken = 1'b1; br_base = 32'h100; br_offset_sl2 = 32'hFFFF_FFF0;
    step();
    redirect_clear();
    chk("branch addr", imem_addr, 32'hF0);
    chk("branch flush", 32'(if_id_valid), 32'd0);
    chk("branch nop", if_id_instr, NOP);
    step();
    chk("branch pc4", if_id_pc4, 32'hF4);

    br_taken = 1'b1; br_base = 32'h200; br_offset_sl2 = 32'h40;
    jmp = 1'b1; jmp_target = 32'h400;
    step();
    redirect_clear();
    chk("br over jmp", imem_addr, 32'h240);
    step();

    imem_ready = 1'b0;
    step();
    chk("pend addr", imem_addr, 32'h244);
    jmp = 1'b1; jmp_target = 32'h300;
    step();
    redirect_clear();
    chk("drain req", 32'(imem_req), 32'd1);
    chk("drain addr", imem_addr, 32'h244);
    step();
    chk("drain hold", imem_addr, 32'h244);
    imem_ready = 1'b1;
    step();
    chk("drain done addr", imem_addr, 32'h300);
    chk("drain dropped", if_id_instr, NOP);
    step();
    chk("after drain pc4", if_id_pc4, 32'h304);
    chk("after drain instr", if_id_instr, 32'hC0DE_0301);

    id_stall = 1'b1;
    step();
    chk("stall req", 32'(imem_req), 32'd0);
    chk("stall pc4", if_id_pc4, 32'h304);
    step();
    chk("stall valid", 32'(if_id_valid), 32'd1);
    jmp = 1'b1; jmp_target = 32'h500;
    step();
    redirect_clear();
    chk("stall redirect valid", 32'(if_id_valid), 32'd0);
    id_stall = 1'b0;
    step();
    chk("stall redirect pc4", if_id_pc4, 32'h504);

    imem_ready = 1'b0;
    step();
    id_stall = 1'b1;
    step();
    chk("stall keeps req", 32'(imem_req), 32'd1);
    chk("stall keeps addr", imem_addr, 32'h504);
    imem_ready = 1'b1;
    step();
    chk("stall no new req", 32'(imem_req), 32'd0);
    id_stall = 1'b0;
    step();

    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    step();
    redirect_clear();
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap next", imem_addr, 32'h0);
    chk("wrap pc4", if_id_pc4, 32'h0);

    jmp = 1'b1; jmp_target = 32'h202;
    step();
    redirect_clear();
    chk("misalign addr", imem_addr, 32'h200);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign fault", 32'(misalign_fault), 32'd1);
    step();
    chk("misalign blocked", 32'(if_id_valid), 32'd0);
`else
    chk("misalign fault", 32'(misalign_fault), 32'd0);
    step();
    chk("misalign pc4", if_id_pc4, 32'h204);
`endif
    jmp = 1'b1; jmp_target = 32'h600;
    step();
    redirect_clear();
    step();
    chk("recover pc4", if_id_pc4, 32'h604);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
